// File: rtl/regfile_mp_pkg.sv
// Shared constants for the d16 register file: default geometry and
// architectural register indices, including the stack/link aliases.
package regfile_mp_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 8;
  localparam int DEFAULT_SEL_W    = $clog2(DEFAULT_NUM_REGS);

  typedef enum logic [DEFAULT_SEL_W-1:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    R2 = 3'd2,
    R3 = 3'd3,
    R4 = 3'd4,
    R5 = 3'd5,
    R6 = 3'd6,
    R7 = 3'd7
  } regIdx_t;

  localparam regIdx_t LR = R6;
  localparam regIdx_t SP = R7;

endpackage

// File: rtl/regfile_mp_busy_scoreboard.sv
// Per-register busy bits: a claim sets a bit, any write to that register
// clears it (the claim wins when both happen), with two registered busy read ports.
module busy_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             claim_en,
  input  logic [SEL_W-1:0] claim_sel,
  input  logic             w0_en,
  input  logic [SEL_W-1:0] w0_sel,
  input  logic             w1_en,
  input  logic [SEL_W-1:0] w1_sel,
  input  logic [SEL_W-1:0] ra_sel,
  input  logic [SEL_W-1:0] rb_sel,
  output logic             ra_busy,
  output logic             rb_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;

  // NOTE: the default assignment at the top keeps this block a pure mux with no latch.
  always_comb begin
    busyNext = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (claim_en && claim_sel == SEL_W'(r)) begin
        busyNext[r] = 1'b1;
      end else if ((w0_en && w0_sel == SEL_W'(r)) || (w1_en && w1_sel == SEL_W'(r))) begin
        busyNext[r] = 1'b0;
      end
    end
    if (ZERO_R0) busyNext[0] = 1'b0;
  end

  // NOTE: state is assigned non-blocking so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      ra_busy <= 1'b0;
      rb_busy <= 1'b0;
    end else if (en) begin
      busy    <= busyNext;
      ra_busy <= BYPASS ? busyNext[ra_sel] : busy[ra_sel];
      rb_busy <= BYPASS ? busyNext[rb_sel] : busy[rb_sel];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with busy scoreboard, optional
// write-to-read bypass and optional hardwired zero register.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SEL_W-1:0]  ra_sel,
  input  logic [SEL_W-1:0]  rb_sel,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              w0_en,
  input  logic [SEL_W-1:0]  w0_sel,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_en,
  input  logic [SEL_W-1:0]  w1_sel,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              claim_en,
  input  logic [SEL_W-1:0]  claim_sel
);

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [DATA_W-1:0] regNext [NUM_REGS];

  // w0 is applied last so it wins a same-register conflict.
  always_comb begin
    regNext = regs;
    if (w1_en) regNext[w1_sel] = w1_data;
    if (w0_en) regNext[w0_sel] = w0_data;
    if (ZERO_R0) regNext[0] = '0;
  end

  // NOTE: the array is reset because software relies on every register starting at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
    end else if (en) begin
      regs    <= regNext;
      ra_data <= BYPASS ? regNext[ra_sel] : regs[ra_sel];
      rb_data <= BYPASS ? regNext[rb_sel] : regs[rb_sel];
    end
  end

  busy_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .BYPASS   (BYPASS),
    .ZERO_R0  (ZERO_R0)
  ) uScoreboard (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .claim_en  (claim_en),
    .claim_sel (claim_sel),
    .w0_en     (w0_en),
    .w0_sel    (w0_sel),
    .w1_en     (w1_en),
    .w1_sel    (w1_sel),
    .ra_sel    (ra_sel),
    .rb_sel    (rb_sel),
    .ra_busy   (ra_busy),
    .rb_busy   (rb_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Checks two register-file builds (bypass / plain, and no-bypass / zero-R0)
// against an array-based model of the architectural rules.
module tb_regfile_mp;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst, en;
  logic [SW-1:0] ra_sel, rb_sel, w0_sel, w1_sel, claim_sel;
  logic [DW-1:0] w0_data, w1_data;
  logic w0_en, w1_en, claim_en;

  logic [DW-1:0] raDataA, rbDataA, raDataB, rbDataB;
  logic raBusyA, rbBusyA, raBusyB, rbBusyB;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mReg  [2][NR];
  logic          mBusy [2][NR];
  logic [DW-1:0] eRaD [2];
  logic [DW-1:0] eRbD [2];
  logic          eRaB [2];
  logic          eRbB [2];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(1'b1), .ZERO_R0(1'b0)) dutA (
    .clk(clk), .rst(rst), .en(en),
    .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(raDataA), .rb_data(rbDataA), .ra_busy(raBusyA), .rb_busy(rbBusyA),
    .w0_en(w0_en), .w0_sel(w0_sel), .w0_data(w0_data),
    .w1_en(w1_en), .w1_sel(w1_sel), .w1_data(w1_data),
    .claim_en(claim_en), .claim_sel(claim_sel)
  );

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(1'b0), .ZERO_R0(1'b1)) dutB (
    .clk(clk), .rst(rst), .en(en),
    .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(raDataB), .rb_data(rbDataB), .ra_busy(raBusyB), .rb_busy(rbBusyB),
    .w0_en(w0_en), .w0_sel(w0_sel), .w0_data(w0_data),
    .w1_en(w1_en), .w1_sel(w1_sel), .w1_data(w1_data),
    .claim_en(claim_en), .claim_sel(claim_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Config 0 = bypass, normal r0; config 1 = no bypass, hardwired r0.
  task automatic modelEdge();
    for (int c = 0; c < 2; c++) begin
      bit byp = (c == 0);
      bit zr  = (c == 1);
      logic [DW-1:0] nReg [NR];
      logic          nBusy [NR];
      if (rst) begin
        for (int r = 0; r < NR; r++) begin
          mReg[c][r]  = '0;
          mBusy[c][r] = 1'b0;
        end
        eRaD[c] = '0; eRbD[c] = '0; eRaB[c] = 1'b0; eRbB[c] = 1'b0;
      end else if (en) begin
        for (int r = 0; r < NR; r++) begin
          nReg[r]  = mReg[c][r];
          nBusy[r] = mBusy[c][r];
        end
        if (w1_en && !(zr && w1_sel == 0)) nReg[w1_sel] = w1_data;
        if (w0_en && !(zr && w0_sel == 0)) nReg[w0_sel] = w0_data;
        for (int r = 0; r < NR; r++) begin
          if (claim_en && int'(claim_sel) == r && !(zr && r == 0)) nBusy[r] = 1'b1;
          else if ((w0_en && int'(w0_sel) == r) || (w1_en && int'(w1_sel) == r)) nBusy[r] = 1'b0;
        end
        eRaD[c] = byp ? nReg[ra_sel]  : mReg[c][ra_sel];
        eRbD[c] = byp ? nReg[rb_sel]  : mReg[c][rb_sel];
        eRaB[c] = byp ? nBusy[ra_sel] : mBusy[c][ra_sel];
        eRbB[c] = byp ? nBusy[rb_sel] : mBusy[c][rb_sel];
        for (int r = 0; r < NR; r++) begin
          mReg[c][r]  = nReg[r];
          mBusy[c][r] = nBusy[r];
        end
      end
    end
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
    check("A.ra_data", 32'(raDataA), 32'(eRaD[0]));
    check("A.rb_data", 32'(rbDataA), 32'(eRbD[0]));
    check("A.ra_busy", 32'(raBusyA), 32'(eRaB[0]));
    check("A.rb_busy", 32'(rbBusyA), 32'(eRbB[0]));
    check("B.ra_data", 32'(raDataB), 32'(eRaD[1]));
    check("B.rb_data", 32'(rbDataB), 32'(eRbD[1]));
    check("B.ra_busy", 32'(raBusyB), 32'(eRaB[1]));
    check("B.rb_busy", 32'(rbBusyB), 32'(eRbB[1]));
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1;
    w0_en = 1'b0; w1_en = 1'b0; claim_en = 1'b0;
  endtask

  task automatic wr0(input logic [SW-1:0] s, input logic [DW-1:0] d);
    w0_en = 1'b1; w0_sel = s; w0_data = d;
  endtask

  task automatic wr1(input logic [SW-1:0] s, input logic [DW-1:0] d);
    w1_en = 1'b1; w1_sel = s; w1_data = d;
  endtask

  task automatic claim(input logic [SW-1:0] s);
    claim_en = 1'b1; claim_sel = s;
  endtask

  initial begin
    idle();
    ra_sel = '0; rb_sel = '0; w0_sel = '0; w1_sel = '0; claim_sel = '0;
    w0_data = '0; w1_data = '0;
    #2;

    // Reset then read
    rst = 1'b1; cycle();
    idle(); ra_sel = 3'd3; rb_sel = 3'd5; cycle();
    check("reset.ra_data", 32'(raDataA), 32'h0);
    check("reset.rb_busy", 32'(rbBusyA), 32'h0);

    // Disabled write is dropped, enabled write lands
    en = 1'b0; wr0(3'd2, 16'hBEEF); cycle();
    idle(); ra_sel = 3'd2; cycle();
    check("en0.r2", 32'(raDataA), 32'h0);
    wr0(3'd2, 16'hBEEF); cycle();
    idle(); cycle();
    check("write.r2", 32'(raDataA), 32'hBEEF);

    // Bypass versus pre-edge read
    wr0(3'd4, 16'h1234); ra_sel = 3'd4; cycle();
    check("bypass.A", 32'(raDataA), 32'h1234);
    check("nobypass.B", 32'(raDataB), 32'h0);
    idle(); cycle();
    check("nobypass.B2", 32'(raDataB), 32'h1234);

    // Write conflict: w0 wins
    wr0(3'd6, 16'hAAAA); wr1(3'd6, 16'h5555); cycle();
    idle(); ra_sel = 3'd6; cycle();
    check("conflict.A", 32'(raDataA), 32'hAAAA);
    check("conflict.B", 32'(raDataB), 32'hAAAA);

    // Split ports
    wr0(3'd1, 16'h0011); wr1(3'd7, 16'h0077); ra_sel = 3'd1; rb_sel = 3'd7; cycle();
    idle(); cycle();
    check("split.ra", 32'(raDataB), 32'h0011);
    check("split.rb", 32'(rbDataB), 32'h0077);

    // Scoreboard claim / clear / claim-beats-write
    claim(3'd3); rb_sel = 3'd3; cycle();
    check("claim.A", 32'(rbBusyA), 32'h1);
    idle(); cycle();
    check("claim.B", 32'(rbBusyB), 32'h1);
    wr1(3'd3, 16'h0042); cycle();
    idle(); cycle();
    check("clear.busy", 32'(rbBusyA), 32'h0);
    check("clear.data", 32'(rbDataA), 32'h0042);
    claim(3'd3); wr0(3'd3, 16'h0007); cycle();
    idle(); cycle();
    check("claimwins.A", 32'(rbBusyA), 32'h1);
    check("claimwins.B", 32'(rbBusyB), 32'h1);

    // Hardwired zero register
    wr0(3'd0, 16'hFFFF); claim(3'd0); ra_sel = 3'd0; cycle();
    idle(); cycle();
    check("zero.data", 32'(raDataB), 32'h0);
    check("zero.busy", 32'(raBusyB), 32'h0);
    check("r0.dataA", 32'(raDataA), 32'hFFFF);
    check("r0.busyA", 32'(raBusyA), 32'h1);

    // Mid-operation reset
    wr0(3'd5, 16'h9999); claim(3'd5); cycle();
    idle(); rst = 1'b1; ra_sel = 3'd5; rb_sel = 3'd5; cycle();
    check("midrst.data", 32'(raDataA), 32'h0);
    check("midrst.busy", 32'(rbBusyA), 32'h0);
    idle(); cycle();
    check("postrst.data", 32'(raDataA), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      en        = ($urandom_range(0, 99) < 88);
      w0_en     = $urandom_range(0, 1);
      w1_en     = $urandom_range(0, 1);
      claim_en  = ($urandom_range(0, 99) < 35);
      w0_sel    = SW'($urandom_range(0, NR - 1));
      w1_sel    = ($urandom_range(0, 3) == 0) ? w0_sel : SW'($urandom_range(0, NR - 1));
      claim_sel = SW'($urandom_range(0, NR - 1));
      ra_sel    = SW'($urandom_range(0, NR - 1));
      rb_sel    = ($urandom_range(0, 3) == 0) ? ra_sel : SW'($urandom_range(0, NR - 1));
      w0_data   = DW'($urandom);
      w1_data   = DW'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port CPU register file with a per-register busy scoreboard. It provides two registered read ports and two write ports: a primary rD result and a secondary rS writeback, such as post-increment address update. Optional write-to-read bypass and an optional hardwired zero register are selectable. It sits between decode (reads, claims) and writeback (writes) in the d16 pipeline.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of architectural registers (power of two, >=2)
SEL_W, $clog2(NUM_REGS), register select width (derived; do not override)
BYPASS, 1, 1 = read ports return same-cycle write data and busy state; 0 = pre-edge values
ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never busy

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; when 0, no state or output changes
ra_sel  in  SEL_W  read port A select (rD)
rb_sel  in  SEL_W  read port B select (rS)
ra_data  out  DATA_W  registered port A data
rb_data  out  DATA_W  registered port B data
ra_busy  out  1  registered busy flag for ra_sel
rb_busy  out  1  registered busy flag for rb_sel
w0_en  in  1  primary write enable
w0_sel  in  SEL_W  primary write select
w0_data  in  DATA_W  primary write data
w1_en  in  1  secondary write enable
w1_sel  in  SEL_W  secondary write select
w1_data  in  DATA_W  secondary write data
claim_en  in  1  mark claim_sel busy (issue of an instruction writing it)
claim_sel  in  SEL_W  register to claim

Behaviour:
- Reset (rst=1 at posedge, overrides en): all registers 0, all busy bits 0, ra_data/rb_data 0, ra_busy/rb_busy 0.
- All actions occur only on a posedge with en=1 and rst=0. With en=0, everything holds, including the read outputs.
- Writes: reg[w0_sel] <= w0_data if w0_en; reg[w1_sel] <= w1_data if w1_en.
- Write conflict: if w0_sel==w1_sel with both enabled, w0 wins.
- Busy next-state, per register r: set if claim_en && claim_sel==r; otherwise cleared if any enabled write targets r; otherwise held. A claim and a write to the same r in one cycle leaves busy=1, because the new claim supersedes.
- Reads: 1-cycle latency. ra_data/ra_busy are sampled at the edge from ra_sel; port B likewise from rb_sel.
  - BYPASS=1: outputs take the post-edge values (reg_next[sel], busy_next[sel]), so a same-cycle write or claim is visible.
  - BYPASS=0: outputs take the pre-edge values (reg[sel], busy[sel]).
- Both read ports may select the same register; each returns an identical value.
- ZERO_R0=1: writes and claims to register 0 are dropped; reads of register 0 return data 0 and busy 0.
- No undefined outputs: every select value is legal.
- Implementation constraint: nonblocking assignments only. No mixing of blocking reads with nonblocking writes on storage.

Decomposition:
- Shared package/header cpu_constants.vh: default DATA_W and NUM_REGS, and register index constants (R0..R7, SP/LR aliases).
- Sub-module busy_scoreboard: NUM_REGS busy bits with the set/clear priority logic and the two busy read ports.
- regfile_mp instantiates busy_scoreboard and holds the data array and bypass muxes.

Test Plan:
1. Reset then read: rst=1 one cycle; then ra_sel=3, rb_sel=5 -> next cycle ra_data=0, rb_data=0, both busy=0.
2. Write then read: w0 r2=0xBEEF, then ra_sel=2 -> ra_data=0xBEEF one cycle later. With en=0 on the write cycle -> r2 remains 0.
3. Bypass: same cycle w0 r4=0x1234, ra_sel=4 -> BYPASS=1 gives ra_data=0x1234 next cycle; BYPASS=0 gives the old value (0), then 0x1234 on the following read.
4. Write conflict: w0 r6=0xAAAA, w1 r6=0x5555 same cycle -> r6 reads 0xAAAA.
   Split ports: w0 r1=0x0011, w1 r7=0x0077 -> both visible on ports A/B.
5. Scoreboard: claim r3 -> rb_busy=1 when rb_sel=3.
   Then w1 r3=0x0042 -> busy clears, data 0x0042.
   Claim r3 and w0 r3 in the same cycle -> busy stays 1.
6. ZERO_R0=1: w0 r0=0xFFFF plus claim r0 -> ra_sel=0 returns 0, busy 0.
   Mid-operation rst with r5=0x9999 busy -> all regs/busy 0 next cycle.
